// File: rtl/fp_accum_pkg.sv
// Shared types and constants for the streaming fp32 accumulator.
package fp_accum_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_accum_stream_add.sv
// fp_add: pipelined IEEE-754 single-precision adder, round-to-nearest-even.
// The sum is computed in the first stage and carried through LAT registers,
// so q reflects a/b presented LAT clock edges earlier.
module fp_add
  import fp_accum_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);

  // Full fp32 add: specials, alignment with sticky, normalise, RNE rounding.
  function automatic logic [31:0] add_core(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] big;
    logic [31:0] sml;
    logic [7:0]  eb;
    logic [7:0]  es;
    logic [7:0]  d;
    logic [26:0] mb;
    logic [26:0] ms;
    logic [26:0] mask;
    logic [27:0] sum;
    logic [9:0]  e;
    logic [24:0] rm;
    logic [22:0] frac;
    logic        sticky;
    logic        rnd;
    logic        x_nan;
    logic        y_nan;
    logic        x_inf;
    logic        y_inf;
    x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) return 32'h7FC0_0000;
    if (x_inf) return x;
    if (y_inf) return y;
    // Larger magnitude first so the subtraction never goes negative.
    if (x[30:0] >= y[30:0]) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    eb = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    es = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    mb = {big[30:23] != 8'd0, big[22:0], 3'b000};
    ms = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    d  = eb - es;
    if (d >= 8'd27) begin
      sticky = |ms;
      ms     = '0;
    end else begin
      mask   = (27'd1 << d) - 27'd1;
      sticky = |(ms & mask);
      ms     = ms >> d;
    end
    ms[0] = ms[0] | sticky;
    if (big[31] != sml[31]) sum = {1'b0, mb} - {1'b0, ms};
    else                    sum = {1'b0, mb} + {1'b0, ms};
    // Exact cancellation gives +0; only -0 + -0 stays negative.
    if (sum == 28'd0) return {big[31] & sml[31], 31'd0};
    e = {2'b00, eb};
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 10'd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!sum[26] && (e > 10'd1)) begin
          sum = sum << 1;
          e   = e - 10'd1;
        end
      end
    end
    rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
    rm  = {1'b0, sum[26:3]} + {24'd0, rnd};
    if (rm[24]) begin
      e    = e + 10'd1;
      frac = rm[23:1];
    end else begin
      frac = rm[22:0];
      if (!rm[23]) e = 10'd0;   // subnormal result
    end
    if (e >= 10'd255) return {big[31], 8'hFF, 23'd0};
    return {big[31], e[7:0], frac};
  endfunction

  logic [31:0] pipe_q [LAT];

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First stage registers the freshly computed sum.
        always_ff @(posedge clk) begin
          if (areset) pipe_q[gi] <= FP_ZERO;
          else        pipe_q[gi] <= add_core(a, b);
        end
      end else begin : g_delay
        // Remaining stages only delay the result to match the IP latency.
        always_ff @(posedge clk) begin
          if (areset) pipe_q[gi] <= FP_ZERO;
          else        pipe_q[gi] <= pipe_q[gi-1];
        end
      end
    end
  endgenerate

  assign q = pipe_q[LAT-1];

endmodule

// File: rtl/fp_accum_stream.sv
// fp_accum_stream: one-operand-per-cycle fp32 stream summation around a
// single LAT-cycle fp_add. Up to LAT partial sums circulate through the
// adder; after the last element they are paired off via a hold register
// until one remains, which is presented on a valid/ready output.
module fp_accum_stream
  import fp_accum_pkg::*;
#(
  parameter int LAT   = 4,
  parameter int CNT_W = $clog2(LAT + 2)
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  state_e             state_q, state_d;
  logic [LAT-1:0]     vq_q, vq_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic [31:0]        add_a;
  logic [31:0]        add_b;
  logic [31:0]        add_q;
  logic               q_valid;
  logic               in_xfer;
  logic               out_xfer;
  logic               issue;

  // The adder's own reset is unused: stale in-flight data is ignored because
  // the valid shift register is cleared instead.
  fp_add #(.LAT(LAT)) u_add (
    .clk    (clk),
    .areset (1'b0),
    .a      (add_a),
    .b      (add_b),
    .q      (add_q)
  );

  assign q_valid   = vq_q[LAT-1];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state, adder operand selection and handshake decode.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    add_a       = FP_ZERO;
    add_b       = FP_ZERO;
    issue       = 1'b0;
    in_ready    = 1'b0;
    in_xfer     = 1'b0;
    out_xfer    = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = !areset;
        in_xfer  = in_valid && !areset;
        if (in_xfer) add_a = in_data;
        if (q_valid) add_b = add_q;
        // Bubbles still recirculate q+0 so partials keep their slot.
        issue = in_xfer || q_valid;
        if (in_xfer && !q_valid) count_d = count_q + CNT_W'(1);
        if (in_xfer && in_last)  state_d = REDUCE;
      end
      REDUCE: begin
        if (q_valid) begin
          if (hold_full_q) begin
            add_a       = hold_q;
            add_b       = add_q;
            issue       = 1'b1;
            hold_full_d = 1'b0;
            count_d     = count_q - CNT_W'(1);
          end else if (count_q > CNT_W'(1)) begin
            hold_d      = add_q;
            hold_full_d = 1'b1;
          end else begin
            out_data_d  = add_q;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        out_xfer = out_valid_q && out_ready;
        if (out_xfer) begin
          out_valid_d = 1'b0;
          count_d     = '0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
    vq_d = (vq_q << 1) | LAT'(issue);
  end

  // State registers; reset aborts any stream in progress.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q     <= ACCUM;
      vq_q        <= '0;
      count_q     <= '0;
      hold_q      <= FP_ZERO;
      hold_full_q <= 1'b0;
      out_data_q  <= FP_ZERO;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vq_q        <= vq_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fp_accum_stream.sv
// Bench for fp_accum_stream: table of streams with a result scoreboard,
// plus hand-written latency, backpressure and reset-abort sequences.
module tb_fp_accum_stream;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        areset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          out_idx = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;

  typedef struct {
    int          start;
    int          len;
    int          gap;
    logic [31:0] expected;
  } vec_t;

  logic [31:0] ops [0:39];
  vec_t        vecs [0:6];

  always #5 clk = ~clk;

  fp_accum_stream #(.LAT(LAT)) dut (
    .clk       (clk),
    .areset    (areset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %08h, required %08h", name, act, req);
  endtask

  // Scoreboard: an output transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!areset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got %08h, required no output", out_data);
      end else begin
        exp_v = exp_q.pop_front();
        $display("out %0d: sum %08h (expected %08h)", out_idx, out_data, exp_v);
        check($sformatf("stream%0d_sum", out_idx), out_data, exp_v);
      end
      out_idx++;
    end
  end

  task automatic send(input int start, input int len, input int gap,
                      input bit push, input logic [31:0] expected);
    bit done;
    for (int i = 0; i < len; i++) begin
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = ops[start+i];
      in_last  = (i == len - 1);
      if ((i == len - 1) && push) exp_q.push_back(expected);
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        if (in_ready) done = 1'b1;
        @(posedge clk);
        #1;
      end
      if (!done) begin
        total_cnt++;
        $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL %s_timeout: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    bit          seen;
    bit          ready_low;
    bit          stable;
    bit          quiet;
    logic [31:0] held;

    areset    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 40; i++) ops[i] = 32'h3f80_0000;
    ops[0]  = 32'h3f80_0000; ops[1] = 32'h4000_0000;    // 1, 2
    ops[2]  = 32'h4040_0000; ops[3] = 32'h4080_0000;    // 3, 4
    ops[4]  = 32'h3f80_0000; ops[5] = 32'h3f00_0000;    // 1, 0.5
    ops[6]  = 32'hbe80_0000;                            // -0.25
    ops[7]  = 32'h4000_0000; ops[8] = 32'hc000_0000;    // 2, -2
    ops[9]  = 32'h3fc0_0000; ops[10] = 32'h4020_0000;   // 1.5, 2.5
    ops[11] = 32'h4040_0000; ops[12] = 32'hbf80_0000;   // 3, -1
    ops[13] = 32'h3e80_0000;                            // 0.25
    for (int i = 14; i < 22; i++) ops[i] = 32'h3e80_0000; // 8 x 0.25
    ops[32] = 32'h4000_0000;                            // 2

    vecs[0] = '{0,  4, 0, 32'h4120_0000};   // 1+2+3+4 = 10
    vecs[1] = '{4,  3, 1, 32'h3fa0_0000};   // gapped 1.25
    vecs[2] = '{4,  3, 0, 32'h3fa0_0000};   // same, no gap
    vecs[3] = '{7,  2, 0, 32'h0000_0000};   // exact cancellation -> +0
    vecs[4] = '{9,  5, 0, 32'h40c8_0000};   // 6.25
    vecs[5] = '{9,  5, 3, 32'h40c8_0000};   // 6.25 with long gaps
    vecs[6] = '{14, 8, 2, 32'h4000_0000};   // 8 x 0.25 = 2

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready",  {31'd0, in_ready},  32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data",  out_data,           32'd0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Single element: latency from the transfer cycle to out_valid.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 32'h3f80_0000;
    in_last  = 1'b1;
    exp_q.push_back(32'h3f80_0000);
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check("single_latency", lat, LAT + 1);
    drain("single");

    // Table of streams, issued back to back through the scoreboard.
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].start, vecs[v].len, vecs[v].gap, 1'b1, vecs[v].expected);
    end
    drain("table");

    // Ten ones with the consumer stalled: in_ready low, output held stable.
    out_ready = 1'b0;
    send(22, 10, 0, 1'b1, 32'h4120_0000);
    ready_low = 1'b1;
    seen      = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (in_ready) ready_low = 1'b0;
      if (out_valid) seen = 1'b1;
    end
    check("done_reached", {31'd0, seen}, 32'd1);
    held   = out_data;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!out_valid || (out_data !== held) || in_ready) stable = 1'b0;
    end
    check("done_hold_stable", {31'd0, stable}, 32'd1);
    check("done_held_value", held, 32'h4120_0000);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    if (in_ready) ready_low = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("in_ready_low_until_out", {31'd0, ready_low}, 32'd1);
    check("in_ready_after_out",     {31'd0, in_ready},  32'd1);
    check("out_valid_after_out",    {31'd0, out_valid}, 32'd0);
    drain("stall");

    // Reset while reducing: stream aborted, then a clean new stream.
    send(0, 4, 0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_in_ready",  {31'd0, in_ready},  32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out_data",  out_data,           32'd0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    quiet  = 1'b1;
    for (int c = 0; c < 3 * LAT + 10; c++) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    check("no_output_after_abort", {31'd0, quiet}, 32'd1);
    send(32, 1, 0, 1'b1, 32'h4000_0000);
    drain("after_abort");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
